// File: rtl/dm_ctrl_pkg.sv
// Shared widths, opcode values and payload types for the MEM-stage data-memory controller.
package dm_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_LB  = 6'h20;
    localparam logic [OP_W-1:0] OP_LH  = 6'h21;
    localparam logic [OP_W-1:0] OP_LW  = 6'h23;
    localparam logic [OP_W-1:0] OP_LBU = 6'h24;
    localparam logic [OP_W-1:0] OP_LHU = 6'h25;
    localparam logic [OP_W-1:0] OP_SB  = 6'h28;
    localparam logic [OP_W-1:0] OP_SH  = 6'h29;
    localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

    typedef struct packed {
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] data;
        logic            misaligned;
    } store_fmt_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/dm_store_fmt.sv
// Byte-lane enables, lane-replicated store data and alignment check for one MEM-stage op.
module dm_store_fmt
    import dm_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    output store_fmt_t      o_fmt
);

    always_comb begin
        o_fmt = '0;
        case (i_op)
            OP_SB: begin
                o_fmt.be   = 4'b0001 << i_addr_lo;
                o_fmt.data = {4{i_wdata[7:0]}};
            end
            OP_SH: begin
                o_fmt.be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_fmt.data       = {2{i_wdata[15:0]}};
                o_fmt.misaligned = i_addr_lo[0];
            end
            OP_SW: begin
                o_fmt.be         = 4'b1111;
                o_fmt.data       = i_wdata;
                o_fmt.misaligned = |i_addr_lo;
            end
            OP_LB, OP_LBU: begin
                o_fmt.be = 4'b1111;
            end
            OP_LH, OP_LHU: begin
                o_fmt.be         = 4'b1111;
                o_fmt.misaligned = i_addr_lo[0];
            end
            OP_LW: begin
                o_fmt.be         = 4'b1111;
                o_fmt.misaligned = |i_addr_lo;
            end
            default: o_fmt = '0;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// MEM-stage data-memory controller: issues one req/ack access per memory op, stalls the
// pipeline while it is outstanding and registers the MEM/WB payload for the load extender.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mem_valid,
    input  logic            flush,
    input  logic [OP_W-1:0] OP,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall_o,
    output logic            dm_req,
    output logic            dm_we,
    output logic [BE_W-1:0] dm_be,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic [XLEN-1:0] dm_rd_wb,
    output logic [1:0]      ctrl_wb,
    output logic [OP_W-1:0] op_wb,
    output logic            wb_valid,
    output logic            exc_adel,
    output logic            exc_ades,
    output logic            bus_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    store_fmt_t w_fmt;
    logic       w_live;
    logic       w_accept;
    logic       w_bad;
    logic       w_timeout;

    dm_store_fmt u_store_fmt (
        .i_op      (OP),
        .i_addr_lo (addr[1:0]),
        .i_wdata   (wdata),
        .o_fmt     (w_fmt)
    );

    assign w_live    = mem_valid & ~flush;
    assign w_accept  = (r_state == IDLE) & w_live & is_mem(OP) & ~w_fmt.misaligned;
    assign w_bad     = w_live & w_fmt.misaligned;
    assign w_timeout = (r_state == BUSY) & ~dm_ack & (r_cnt == CNT_W'(MAX_WAIT));
    assign stall_o   = w_accept | ((r_state == BUSY) & ~dm_ack & ~w_timeout);

    // A flush while BUSY never cancels the access; it only clears wb_valid at the ack edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_rd_wb <= '0;
            ctrl_wb  <= '0;
            op_wb    <= '0;
            wb_valid <= 1'b0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    ctrl_wb  <= addr[1:0];
                    op_wb    <= OP;
                    dm_rd_wb <= '0;
                    if (w_accept) begin
                        r_state  <= BUSY;
                        r_cnt    <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= is_store(OP);
                        dm_be    <= w_fmt.be;
                        dm_addr  <= {addr[XLEN-1:2], 2'b00};
                        dm_wdata <= w_fmt.data;
                        wb_valid <= 1'b0;
                    end else begin
                        wb_valid <= w_live & ~w_fmt.misaligned;
                        exc_adel <= w_bad & is_load(OP);
                        exc_ades <= w_bad & is_store(OP);
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        r_state  <= IDLE;
                        dm_req   <= 1'b0;
                        wb_valid <= w_live;
                        dm_rd_wb <= is_load(op_wb) ? dm_rdata : '0;
                    end else if (w_timeout) begin
                        r_state  <= IDLE;
                        dm_req   <= 1'b0;
                        wb_valid <= 1'b0;
                        dm_rd_wb <= '0;
                        bus_err  <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                        wb_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed vector table, corner sequences and random accesses.
module tb_dm_ctrl;
    import dm_ctrl_pkg::*;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_valid;
    logic        flush;
    logic [5:0]  OP;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_o;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] dm_rd_wb;
    logic [1:0]  ctrl_wb;
    logic [5:0]  op_wb;
    logic        wb_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .flush(flush), .OP(OP),
        .addr(addr), .wdata(wdata), .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we),
        .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .dm_rd_wb(dm_rd_wb), .ctrl_wb(ctrl_wb), .op_wb(op_wb),
        .wb_valid(wb_valid), .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        adel;
        logic        ades;
    } vec_t;

    vec_t       vt[8];
    logic [5:0] ops[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes from the opcode; 0 for non-memory ops.
    function automatic int unsigned acc_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Drive one MEM-stage instruction to completion; ack arrives after d wait cycles,
    // flush rises at BUSY cycle fl_at (if >= 0) and stays high.
    task automatic run_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                              input bit valid, input bit fl0, input int unsigned d,
                              input int fl_at, input logic [31:0] rd);
        int unsigned sz, exp_stall, n_cyc, stalls, off;
        bit          live, misal, acc, done, st, fl_ack;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        sz        = acc_size(op);
        st        = op_is_store(op);
        live      = valid && !fl0;
        misal     = (sz != 0) && ((a % sz) != 0);
        acc       = live && (sz != 0) && !misal;
        done      = (d <= MW);
        exp_stall = acc ? 1 + (done ? d : MW) : 0;
        n_cyc     = acc ? 1 + (done ? d + 1 : MW + 1) : 1;
        fl_ack    = (fl_at >= 0) && (int'(d) + 1 >= fl_at);
        off       = a % 4;
        exp_wd    = '0;
        exp_be    = '0;
        stalls    = 0;
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                exp_wd[8*k +: 8] = wd[8*(k % sz) +: 8];
                exp_be[k]        = !st || ((k >= off) && (k < off + sz));
            end
        end
        OP = op; addr = a; wdata = wd; mem_valid = valid; flush = fl0;
        for (int unsigned c = 0; c < n_cyc; c++) begin
            if (c == 0) begin
                dm_ack   = 1'($urandom % 2);
                dm_rdata = $urandom;
            end else begin
                dm_ack   = (c == d + 1);
                dm_rdata = dm_ack ? rd : $urandom;
                if (fl_at >= 0 && int'(c) >= fl_at) flush = 1'b1;
            end
            #1;
            if (stall_o) stalls++;
            if (c > 0) chk("busy_req", dm_req, 1);
            tick();
            if (acc && c == 0) begin
                chk("issue_req", dm_req, 1);
                chk("issue_we", dm_we, st);
                chk("issue_be", dm_be, exp_be);
                chk("issue_addr", dm_addr, {a[31:2], 2'b00});
                if (st) chk("issue_wdata", dm_wdata, exp_wd);
            end
        end
        dm_ack = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        chk("stall_cycles", stalls, exp_stall);
        chk("end_req", dm_req, 0);
        chk("wb_valid", wb_valid, acc ? (done && !fl_ack) : (live && !misal));
        chk("dm_rd_wb", dm_rd_wb, (acc && done && !st) ? rd : 32'h0);
        chk("op_wb", op_wb, op);
        chk("ctrl_wb", ctrl_wb, a[1:0]);
        chk("exc_adel", exc_adel, live && misal && !st);
        chk("exc_ades", exc_ades, live && misal && st);
        chk("bus_err", bus_err, acc && !done);
    endtask

    initial begin
        vt[0] = '{OP_SB,  32'h23,  32'h000000A5, 1, 1, 4'b1000, 32'h20,  32'hA5A5A5A5, 0, 0};
        vt[1] = '{OP_SH,  32'h32,  32'h1234BEEF, 1, 1, 4'b1100, 32'h30,  32'hBEEFBEEF, 0, 0};
        vt[2] = '{OP_SW,  32'h44,  32'hCAFEF00D, 1, 1, 4'b1111, 32'h44,  32'hCAFEF00D, 0, 0};
        vt[3] = '{OP_LB,  32'h101, 32'h0,        1, 0, 4'b1111, 32'h100, 32'h0,        0, 0};
        vt[4] = '{OP_SH,  32'h31,  32'h5555AAAA, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 1};
        vt[5] = '{OP_LW,  32'h22,  32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1, 0};
        vt[6] = '{OP_SB,  32'h11,  32'h0000007F, 1, 1, 4'b0010, 32'h10,  32'h7F7F7F7F, 0, 0};
        vt[7] = '{OP_LHU, 32'h06,  32'h0,        1, 0, 4'b1111, 32'h04,  32'h0,        0, 0};
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'h00, 6'h0F};

        rstn = 1'b0; mem_valid = 1'b0; flush = 1'b0; OP = '0; addr = '0; wdata = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        tick(); tick();
        chk("rst_req", dm_req, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_op_wb", op_wb, 0);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            OP = vt[i].op; addr = vt[i].a; wdata = vt[i].wd; mem_valid = 1'b1; dm_ack = 1'b0;
            #1;
            chk("vec_stall", stall_o, vt[i].req);
            tick();
            chk("vec_req", dm_req, vt[i].req);
            chk("vec_adel", exc_adel, vt[i].adel);
            chk("vec_ades", exc_ades, vt[i].ades);
            if (vt[i].req) begin
                chk("vec_we", dm_we, vt[i].we);
                chk("vec_be", dm_be, vt[i].be);
                chk("vec_addr", dm_addr, vt[i].da);
                if (vt[i].we) chk("vec_wdata", dm_wdata, vt[i].dwd);
                dm_ack = 1'b1;
            end else begin
                chk("vec_wb_valid_mis", wb_valid, 0);
                mem_valid = 1'b0;
            end
            #1;
            chk("vec_stall2", stall_o, 0);
            tick();
            dm_ack = 1'b0; mem_valid = 1'b0;
            chk("vec_req_drop", dm_req, 0);
            chk("vec_exc_once", exc_adel | exc_ades, 0);
            chk("vec_wb_valid", wb_valid, vt[i].req);
        end

        // LW with ack after three wait cycles
        run_access(OP_LW, 32'h10, 32'h0, 1, 0, 3, -1, 32'hDEADBEEF);
        // LH that is never acknowledged
        run_access(OP_LH, 32'h42, 32'h0, 1, 0, 100, -1, 32'h0);
        #1;
        chk("timeout_idle_stall", stall_o, 0);
        // SW flushed while waiting for ack
        run_access(OP_SW, 32'h80, 32'h01020304, 1, 0, 3, 2, 32'h0);
        // flush coinciding with ack
        run_access(OP_LW, 32'h84, 32'h0, 1, 0, 2, 3, 32'h12345678);
        // non-memory op and flushed memory op in IDLE
        run_access(6'h00, 32'h7, 32'h0, 1, 0, 0, -1, 32'h0);
        run_access(OP_SB, 32'h9, 32'hFF, 1, 1, 0, -1, 32'h0);

        // synchronous reset in the middle of BUSY
        OP = OP_LW; addr = 32'h88; mem_valid = 1'b1; dm_ack = 1'b0;
        tick();
        chk("pre_rst_req", dm_req, 1);
        tick();
        rstn = 1'b0; mem_valid = 1'b0;
        tick();
        chk("midrst_req", dm_req, 0);
        chk("midrst_be", dm_be, 0);
        chk("midrst_addr", dm_addr, 0);
        chk("midrst_op_wb", op_wb, 0);
        chk("midrst_ctrl_wb", ctrl_wb, 0);
        rstn = 1'b1;
        #1;
        chk("midrst_stall", stall_o, 0);
        tick();
        run_access(OP_LBU, 32'h83, 32'h0, 1, 0, 1, -1, 32'hA1B2C3D4);

        for (int i = 0; i < 80; i++) begin
            int unsigned d;
            int          fl_at;
            d     = $urandom_range(0, 6);
            fl_at = (($urandom % 4) == 0) ? int'($urandom_range(1, d + 1)) : -1;
            run_access(ops[$urandom_range(0, 9)], $urandom, $urandom,
                       ($urandom % 8) != 0, ($urandom % 8) == 0, d, fl_at, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
